// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//   MEM stage of the RV32IM pipeline. Takes EX/MEM values, runs loads and
//   stores over a request/ready data-memory port and forwards results to
//   MEM/WB. Non-memory instructions pass straight through. While an access
//   is outstanding, stall freezes the upstream pipeline.
//
//   FSM: IDLE -> REQ -> DONE -> IDLE. A misaligned access may skip REQ
//   (see MISALIGN_TRAP_EN below).
//
//   Ports:
//     clk, reset (sync, active-low)
//     EX/MEM in : ALU_result, ALUD, data2, funct3, rd, memory_read_enable,
//                 memory_write_enable, regwrite_enable, mux3_select
//     memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en (out),
//                 mem_ready, mem_rdata (in)
//     pipeline  : stall, read_data, ALUD_out, rd_out,
//                 regwrite_enable_out, mux3_select_out
//     status    : bus_error (timeout pulse), misaligned (trap pulse)
//
//   Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses. Without it, the offending low address bits are ignored.
// ---------------------------------------------------------------------------
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ALUD,
  input  logic [31:0] data2,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        memory_read_enable,
  input  logic        memory_write_enable,
  input  logic        regwrite_enable,
  input  logic        mux3_select,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic        stall,
  output logic [31:0] read_data,
  output logic [31:0] ALUD_out,
  output logic [4:0]  rd_out,
  output logic        regwrite_enable_out,
  output logic        mux3_select_out,
  output logic        bus_error,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [TIMEOUT_W-1:0]   r_cnt;
  logic [TIMEOUT_W-1:0]   w_cnt_inc;
  logic                   w_timeout;
  logic [2:0]             r_funct3;
  logic [1:0]             r_addr_lo;
  logic                   r_is_read;
  logic [31:0]            r_alud;
  logic [4:0]             r_rd;
  logic                   r_regwrite;
  logic                   r_mux3;
  logic                   w_mem_op;
  logic                   w_wr_op;
  logic                   w_rd_op;
  logic                   w_misaligned;

  // Extend the selected byte/half of a read word according to funct3.
  function automatic logic [31:0] f_load_ext(input logic [2:0] f3,
                                             input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  f_load_ext = {{24{b[7]}}, b};
      3'b001:  f_load_ext = {{16{h[15]}}, h};
      3'b010:  f_load_ext = d;
      3'b100:  f_load_ext = {24'd0, b};
      3'b101:  f_load_ext = {16'd0, h};
      default: f_load_ext = 32'd0;
    endcase
  endfunction

  // Byte-lane enables; store codes with funct3[2] set are not valid sizes.
  function automatic logic [3:0] f_byte_en(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic       is_write);
    if (is_write && f3[2]) begin
      f_byte_en = 4'b0000;
    end else begin
      case (f3[1:0])
        2'b00:   f_byte_en = 4'b0001 << a;
        2'b01:   f_byte_en = a[1] ? 4'b1100 : 4'b0011;
        2'b10:   f_byte_en = 4'b1111;
        default: f_byte_en = 4'b0000;
      endcase
    end
  endfunction

  // Replicate store data across lanes so any enabled lane sees it.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    case (f3[1:0])
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=00.
  function automatic logic f_is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: f_is_misaligned = a[0];
      3'b010:         f_is_misaligned = (a != 2'b00);
      default:        f_is_misaligned = 1'b0;
    endcase
  endfunction

  // Write wins when both enables are set.
  assign w_wr_op   = memory_write_enable;
  assign w_rd_op   = memory_read_enable & ~memory_write_enable;
  assign w_mem_op  = memory_read_enable | memory_write_enable;
  assign w_cnt_inc = r_cnt + TIMEOUT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     (w_cnt_inc == TIMEOUT_W'(TIMEOUT_CYCLES));

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = w_mem_op & f_is_misaligned(funct3, ALU_result[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          w_next_state = w_misaligned ? S_DONE : S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ready || w_timeout) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Stall and MEM/WB forwarding: live inputs in IDLE, latched copy otherwise.
  always_comb begin
    stall               = 1'b0;
    ALUD_out            = ALUD;
    rd_out              = rd;
    regwrite_enable_out = regwrite_enable;
    mux3_select_out     = mux3_select;
    case (r_state)
      S_IDLE: begin
        stall = w_mem_op;
      end
      S_REQ: begin
        stall               = 1'b1;
        ALUD_out            = r_alud;
        rd_out              = r_rd;
        regwrite_enable_out = r_regwrite;
        mux3_select_out     = r_mux3;
      end
      S_DONE: begin
        stall               = 1'b0;
        ALUD_out            = r_alud;
        rd_out              = r_rd;
        // A failed access must not write back.
        regwrite_enable_out = r_regwrite & ~bus_error & ~misaligned;
        mux3_select_out     = r_mux3;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // State register, request port, latched instruction and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_is_read   <= 1'b0;
      r_alud      <= 32'd0;
      r_rd        <= 5'd0;
      r_regwrite  <= 1'b0;
      r_mux3      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_byte_en <= 4'd0;
      read_data   <= 32'd0;
      bus_error   <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          r_cnt      <= '0;
          read_data  <= 32'd0;
          bus_error  <= 1'b0;
          misaligned <= 1'b0;
          if (w_mem_op) begin
            r_funct3   <= funct3;
            r_addr_lo  <= ALU_result[1:0];
            r_is_read  <= w_rd_op;
            r_alud     <= ALUD;
            r_rd       <= rd;
            r_regwrite <= regwrite_enable;
            r_mux3     <= mux3_select;
            mem_addr   <= {ALU_result[31:2], 2'b00};
            mem_wdata  <= f_wdata(funct3, data2);
            if (w_misaligned) begin
              misaligned <= 1'b1;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= w_wr_op;
              mem_byte_en <= f_byte_en(funct3, ALU_result[1:0], w_wr_op);
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_byte_en <= 4'd0;
            read_data   <= r_is_read ? f_load_ext(r_funct3, r_addr_lo, mem_rdata)
                                     : 32'd0;
          end else if (w_timeout) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_byte_en <= 4'd0;
            read_data   <= 32'd0;
            bus_error   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_cnt      <= '0;
          read_data  <= 32'd0;
          bus_error  <= 1'b0;
          misaligned <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Consumer of the execute-stage outputs (via EX/MEM register): performs data-memory loads and stores for the RV32IM pipeline and forwards results to the MEM/WB register.
- Drives a request/ready data-memory port: sizes stores, extends loads and stalls the upstream pipeline while an access is outstanding.
- Non-memory instructions pass through with zero added latency.

Parameters:
- TIMEOUT_CYCLES, 255, max wait cycles in REQ before a bus error is declared; 0 disables the timeout.
- TIMEOUT_W, 8, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- ALU_result  input  32  effective address / ALU value from EX
- ALUD  input  32  writeback candidate (pc4 or ALU result) from EX
- data2  input  32  store data
- funct3  input  3  access size/sign
- rd  input  5  destination register
- memory_read_enable  input  1  load
- memory_write_enable  input  1  store
- regwrite_enable  input  1  writeback enable
- mux3_select  input  1  writeback mux select
- mem_ready  input  1  memory completes access this cycle
- mem_rdata  input  32  memory read word
- mem_req  output  1  access request (registered)
- mem_we  output  1  1=write
- mem_addr  output  32  word address, {ALU_result[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_byte_en  output  4  byte lane enables
- stall  output  1  freeze PC/IF/ID/EX/EX-MEM registers
- read_data  output  32  extended load data
- ALUD_out, rd_out, regwrite_enable_out, mux3_select_out  output  32/5/1/1  forwarded to MEM/WB
- bus_error  output  1  one-cycle pulse on timeout
- misaligned  output  1  one-cycle pulse on misaligned access (see Optional Feature)

Behaviour:
- FSM: IDLE, REQ, DONE. Reset (reset=0 at an edge) → IDLE; mem_req, mem_we, mem_byte_en, read_data, bus_error, misaligned, wait counter all 0.
- Reset mid-access: mem_req drops at that edge; a later mem_ready is ignored.
- IDLE, no memory op:
  - Pass-through of ALUD/rd/regwrite_enable/mux3_select; stall=0; read_data=0.
- IDLE, read or write enable set:
  - stall=1 combinationally.
  - Latch address, store data, funct3, rd and controls.
  - Next edge → REQ with mem_req=1.
  - Write has priority if both enables are set; the read is ignored.
- REQ:
  - stall=1; mem_req/mem_we/mem_addr/mem_wdata/mem_byte_en held stable.
  - Wait counter increments each cycle.
  - mem_ready=1 at an edge → DONE, mem_req=0. For a load, the extended mem_rdata is registered into read_data.
  - Counter reaching TIMEOUT_CYCLES (if nonzero) with no mem_ready → DONE, bus_error=1 for the DONE cycle, read_data=0, regwrite_enable_out=0.
- DONE (exactly 1 cycle):
  - stall=0; outputs are driven from the latched copy.
  - The pipeline advances at this edge; current inputs are not re-serviced; → IDLE.
  - Minimum memory-op latency is 3 cycles (IDLE, REQ with immediate ready, DONE).
- Load extension, by funct3 and address bits [1:0]:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend half selected by addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Other codes: read_data=0.
- Store sizing:
  - SB: byte_en=4'b0001<<addr[1:0]; wdata = byte ×4.
  - SH: byte_en = addr[1] ? 1100 : 0011; wdata = half ×2.
  - SW: byte_en=1111.
  - Other codes: byte_en=0000, still handshaken.
- mem_req rules:
  - Never asserted outside REQ.
  - Once asserted, never deasserted before mem_ready, timeout or reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - A misaligned access skips REQ: IDLE → DONE, no mem_req.
  - misaligned=1 during DONE; regwrite_enable_out=0; read_data=0.
- Undefined:
  - misaligned tied 0.
  - Offending low address bits are ignored: half-word uses addr[1] only, word ignores addr[1:0]; the access proceeds normally.

Test Plan:
- Reset: hold reset=0 for 2 cycles during REQ → mem_req=0 next cycle, state IDLE, stall=0; a later mem_ready=1 causes no output change.
- LB: addr 0x1003, mem_rdata 0x80FF_FF12, mem_ready on the first REQ cycle → read_data=0xFFFF_FF80 in DONE, stall high for exactly 2 cycles.
- LHU: addr 0x2002, mem_rdata 0xBEEF_1234, 3 wait cycles → read_data=0x0000_BEEF; stall high for 5 cycles.
- SB/SH: SB addr 0x3001, data2 0x0000_00AB → byte_en=0010, wdata=0xABAB_ABAB. SH addr 0x3002 → byte_en=1100.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 → bus_error pulses once after 4 REQ cycles, regwrite_enable_out=0, mem_req drops.
- MISALIGN_TRAP_EN: LW addr 0x4002 → no mem_req, misaligned=1 for one cycle, regwrite_enable_out=0. Without the macro → mem_addr=0x4000, byte_en=1111.
